// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32x32 register file.
// Zero-fills x1..x31 after reset or on request, then shares the single
// write port between NREQ writeback requesters with round-robin arbitration.
module regfile_wr_ctrl #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 init_done,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [XLEN-1:0]      wr_data
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     cnt;
    logic [RRW-1:0]    rr;
    logic [RRW-1:0]    rr_nxt;
    logic [RRW-1:0]    grant;
    logic              grant_vld;
    logic              xfer;
    logic [AW-1:0]     sel_addr;
    logic [XLEN-1:0]   sel_data;
    int                idx;

    assign init_done = (state == RUN);

    // Round-robin search starting at rr; no grant while clearing or when a clear is requested.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (state == RUN && !clear_req) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!grant_vld && req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant     = idx[RRW-1:0];
                end
            end
        end
    end

    // Ready is one-hot on the winner; selected address/data and next pointer follow the grant.
    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant] = 1'b1;
        xfer     = grant_vld;
        sel_addr = req_addr[int'(grant)*AW +: AW];
        sel_data = req_data[int'(grant)*XLEN +: XLEN];
        rr_nxt   = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end

    // Next-state logic: clear finishes after loading the last address, RUN leaves on clear_req.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == {AW{1'b1}}) state_nxt = RUN;
            RUN:     if (clear_req)         state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nxt;
    end

    // Clear counter, round-robin pointer and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= AW'(1);
            rr      <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (state == CLEAR) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt;
            wr_data <= '0;
            cnt     <= cnt + 1'b1;
        end else if (clear_req) begin
            // rr is kept so fairness survives a re-clear
            cnt   <= AW'(1);
            wr_en <= 1'b0;
        end else if (xfer) begin
            // writes to x0 are accepted but never reach the register file
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            rr      <= rr_nxt;
        end else begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed self-checking bench for regfile_wr_ctrl (NREQ=3, XLEN=32, AW=5).
module tb_regfile_wr_ctrl;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 clear_req;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 init_done;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;

    int n_tests;
    int n_fail;

    regfile_wr_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .init_done (init_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},     64'(wr_en),     64'd0);
        check({tag, "_wr_addr"},   64'(wr_addr),   64'd0);
        check({tag, "_wr_data"},   64'(wr_data),   64'd0);
        check({tag, "_init_done"}, 64'(init_done), 64'd0);
        check({tag, "_ready"},     64'(req_ready), 64'd0);
    endtask

    task automatic check_write(input string tag, input logic en, input logic [AW-1:0] a,
                               input logic [XLEN-1:0] d);
        check({tag, "_wr_en"},   64'(wr_en),   64'(en));
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'(a));
        check({tag, "_wr_data"}, 64'(wr_data), 64'(d));
    endtask

    logic [XLEN-1:0] dat [NREQ];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clear_req = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        dat[0] = 32'h0000_000A;
        dat[1] = 32'h0000_000B;
        dat[2] = 32'h0000_000C;

        // Reset state
        repeat (2) tick();
        check_reset_outputs("rst");

        // Clear sequence after reset release: addr 1..31, data 0
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check_write($sformatf("clr%0d", k), 1'b1, AW'(k), '0);
            check($sformatf("clr%0d_init", k), 64'(init_done), 64'(k == 31));
        end
        tick();
        check("post_clr_wr_en", 64'(wr_en), 64'd0);
        check("post_clr_init", 64'(init_done), 64'd1);

        // All three requesters valid: grants 0,1,2,0,1,2
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(5 + i), dat[i]);
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            #1;
            check($sformatf("rr%0d_ready", n), 64'(req_ready), 64'(3'b001 << (n % 3)));
            tick();
            check_write($sformatf("rr%0d", n), 1'b1, AW'(5 + n % 3), dat[n % 3]);
        end
        req_valid = '0;
        tick();
        check("idle_wr_en", 64'(wr_en), 64'd0);
        check("idle_wr_addr_hold", 64'(wr_addr), 64'd7);

        // Requester 1 alone writing x0: consumed, discarded, rr moves to 2
        set_req(1, '0, 32'hFFFF_FFFF);
        req_valid = 3'b010;
        #1;
        check("x0_ready", 64'(req_ready), 64'b010);
        tick();
        check("x0_wr_en", 64'(wr_en), 64'd0);
        set_req(1, AW'(6), dat[1]);
        req_valid = 3'b111;
        #1;
        check("x0_rr_is_2", 64'(req_ready), 64'b100);
        tick();
        check_write("after_x0", 1'b1, AW'(7), dat[2]);

        // Requester 2 last granted; 0 and 2 valid -> 0 wins after wrap
        req_valid = 3'b101;
        #1;
        check("wrap_ready", 64'(req_ready), 64'b001);
        tick();
        check_write("wrap", 1'b1, AW'(5), dat[0]);

        // clear_req with requester 0 valid: no grant, idle cycle, then full clear
        req_valid = 3'b001;
        clear_req = 1'b1;
        #1;
        check("clrreq_ready", 64'(req_ready), 64'd0);
        tick();
        clear_req = 1'b0;
        check("clrreq_wr_en", 64'(wr_en), 64'd0);
        check("clrreq_init", 64'(init_done), 64'd0);
        #1;
        check("clrreq_ready_in_clear", 64'(req_ready), 64'd0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            check_write($sformatf("reclr%0d", k), 1'b1, AW'(k), '0);
            check($sformatf("reclr%0d_ready", k), 64'(req_ready), (k == 31) ? 64'b001 : 64'd0);
        end
        check("reclr_init", 64'(init_done), 64'd1);
        tick();
        check_write("served_after_clr", 1'b1, AW'(5), dat[0]);
        req_valid = '0;

        // Reset mid-clear at addr 12, then restart from addr 1
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        check_write("mid_clr12", 1'b1, AW'(12), '0);
        rst_n     = 1'b0;
        req_valid = 3'b001;
        #1;
        check_reset_outputs("async_rst");
        rst_n = 1'b1;
        tick();
        check_write("restart1", 1'b1, AW'(1), '0);
        check("restart1_ready", 64'(req_ready), 64'd0);
        tick();
        check_write("restart2", 1'b1, AW'(2), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
